reg_file: RTL and testbench
===========================

# reg_file

Parametrised multi-port register file, successor to the fixed 16-bit single register. Provides DEPTH words of WIDTH bits with two combinational read ports, one synchronous write port, and a per-register pending scoreboard. The scoreboard lets the CPU issue stage reserve a destination register and lets the read stage detect operands not yet written back. It sits between the decode/issue stage and the writeback stage of the CPU datapath.

## Interface
- WIDTH, 16: bits per register.
- DEPTH, 16: number of registers; power of two, ≥2.
- ZERO_REG, 1: when 1, register 0 always reads 0, ignores writes, and is never pending.
- AW, $clog2(DEPTH): address width (derived; not overridden).

- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_addr_a / rd_addr_b  in  AW  read addresses.
- rd_data_a / rd_data_b  out  WIDTH  read data (combinational).
- rd_ready_a / rd_ready_b  out  1  addressed register not pending.
- claim_en  in  1  request to reserve a destination register.
- claim_addr  in  AW  register to reserve.
- claim_ack  out  1  claim accepted this cycle (combinational).
- pending  out  DEPTH  scoreboard bit vector, bit i = register i pending.

## Operation
- Storage: DEPTH×WIDTH flops plus DEPTH pending bits.
- Write: on edge with wr_en=1 and reset=1, reg[wr_addr] ← wr_data and pending[wr_addr] ← 0, unless cleared bit is re-set by a same-cycle claim (below). Writes to a non-pending register are legal.
- Claim: claim_ack = claim_en & (!pending[claim_addr] | (wr_en & wr_addr==claim_addr)). On ack, pending[claim_addr] ← 1 at the edge. Non-acked claim changes nothing; requester retries.
- Simultaneous write and claim, same address: data written, pending ends 1 (claim wins).
- Register 0 with ZERO_REG=1: rd_data=0, rd_ready=1, claim_ack=claim_en, pending[0] constant 0, writes dropped.
- Reads: rd_data_x = reg[rd_addr_x]; rd_ready_x = !pending[rd_addr_x]. Both ports may address the same register.
- Reset (reset=0 at edge): all registers 0, all pending 0; reset dominates wr_en and claim_en. Mid-operation reset discards all outstanding claims.

## Timing
- Write latency: 1 cycle; data visible on read ports the cycle after the write edge (bypass off).
- Claim latency: pending set visible the cycle after ack.
- Read path: purely combinational from rd_addr and state; no read latency.
- claim_ack is combinational from claim_en, claim_addr, wr_en, wr_addr and state; callers register it if crossing stages.
- Reset values after first reset edge: rd_data_a/b = 0, rd_ready_a/b = 1, pending = 0, claim_ack = claim_en.

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding. When wr_en=1 and rd_addr_x==wr_addr (and not the zero register), rd_data_x = wr_data and rd_ready_x = 1 in the same cycle.
- Undefined: no forwarding; read ports show stored value and stored pending state only; written value appears next cycle.
- Claim/scoreboard behaviour identical in both builds.

## Structure
- Package reg_file_pkg: default WIDTH/DEPTH constants, reg_addr_t/reg_word_t typedefs, ZERO_REG default.
- Sub-module reg_file_scoreboard: pending vector, claim_ack logic, set/clear priority; instantiated once in reg_file. Data array and read muxes stay in the top.

## Test plan
- Reset: write 0xBEEF to r3, assert reset=0 one edge -> r3 reads 0x0000, pending=0, rd_ready=1 on all addresses.
- Write/read: write 0x1234 to r5, read r5 on both ports next cycle -> 0x1234 on both; same cycle (bypass off) -> old value 0x0000.
- Scoreboard: claim r7 -> claim_ack=1, next cycle pending[7]=1, rd_ready=0 for r7; second claim r7 -> claim_ack=0; write 0x00AA to r7 -> pending[7]=0, reads 0x00AA.
- Simultaneous: r2 pending, same cycle write 0x5555 and claim r2 -> claim_ack=1, r2=0x5555, pending[2] stays 1.
- Zero register (ZERO_REG=1): write 0xFFFF to r0, claim r0 -> reads 0, claim_ack=1, pending[0]=0.
- Bypass build: write 0x9ABC to r4 with rd_addr_a=4 same cycle -> rd_data_a=0x9ABC, rd_ready_a=1 even if r4 was pending.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the register file slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH / DEFAULT_ZERO_REG : parameter defaults
//   reg_addr_t / reg_word_t                          : address and word types
//                                                      at the default geometry
package reg_file_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_DEPTH    = 16;
  localparam int DEFAULT_ZERO_REG = 1;
  localparam int DEFAULT_AW       = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_AW-1:0]    reg_addr_t;
  typedef logic [DEFAULT_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: bus between issue/read/writeback stages and the register file.
//   master : drives write port, read addresses and claim requests
//   slave  : the register file; returns read data, ready flags, claim_ack and
//            the pending scoreboard vector
interface reg_file_if import reg_file_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_ready_a;
  logic             rd_ready_b;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;
  logic             claim_ack;
  logic [DEPTH-1:0] pending;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, claim_en, claim_addr,
    input  rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, claim_ack, pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, claim_en, claim_addr,
    output rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, claim_ack, pending
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register pending bits and claim arbitration.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   wr_en_i, wr_addr_i   : writeback that clears a pending bit
//   claim_en_i/_addr_i   : reservation request
//   claim_ack_o          : combinational grant
//   pending_o            : scoreboard vector
module reg_file_scoreboard import reg_file_pkg::*; #(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = DEFAULT_ZERO_REG,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             claim_en_i,
  input  logic [AW-1:0]    claim_addr_i,
  output logic             claim_ack_o,
  output logic [DEPTH-1:0] pending_o
);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             claim_ack;

  always_comb begin
    pending_d = pending_q;
    claim_ack = 1'b0;
    // A register being written back this cycle is free to re-claim.
    if (claim_en_i) begin
      claim_ack = !pending_q[claim_addr_i] ||
                  (wr_en_i && (wr_addr_i == claim_addr_i));
    end
    if (wr_en_i) begin
      pending_d[wr_addr_i] = 1'b0;
    end
    // Set after clear so a same-address claim wins over the writeback.
    if (claim_ack) begin
      pending_d[claim_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign claim_ack_o = claim_ack;
  assign pending_o   = pending_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, two combinational read ports, one
// synchronous write port and a pending scoreboard for issue/read hazards.
//   CLK   : clock, all state updates on rising edge
//   reset : synchronous active-low reset (clears data and pending)
//   bus   : reg_file_if.slave (write port, read ports, claim, pending)
// Build option: define REG_FILE_BYPASS_EN to forward a same-cycle write to
// the read ports; default build shows stored state only.
module reg_file import reg_file_pkg::*; #(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
  input logic       CLK,
  input logic       reset,
  reg_file_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             claim_ack;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_ready_a;
  logic             rd_ready_b;

  function automatic logic is_zero(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (CLK),
    .rst_ni       (reset),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .claim_en_i   (bus.claim_en),
    .claim_addr_i (bus.claim_addr),
    .claim_ack_o  (claim_ack),
    .pending_o    (pending)
  );

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && !is_zero(bus.wr_addr)) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_a  = regs_q[bus.rd_addr_a];
    rd_ready_a = !pending[bus.rd_addr_a];
`ifdef REG_FILE_BYPASS_EN
    if (bus.wr_en && (bus.rd_addr_a == bus.wr_addr)) begin
      rd_data_a  = bus.wr_data;
      rd_ready_a = 1'b1;
    end
`endif
    // Zero register overrides any forwarding.
    if (is_zero(bus.rd_addr_a)) begin
      rd_data_a  = '0;
      rd_ready_a = 1'b1;
    end
  end

  always_comb begin
    rd_data_b  = regs_q[bus.rd_addr_b];
    rd_ready_b = !pending[bus.rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (bus.wr_en && (bus.rd_addr_b == bus.wr_addr)) begin
      rd_data_b  = bus.wr_data;
      rd_ready_b = 1'b1;
    end
`endif
    if (is_zero(bus.rd_addr_b)) begin
      rd_data_b  = '0;
      rd_ready_b = 1'b1;
    end
  end

  assign bus.rd_data_a  = rd_data_a;
  assign bus.rd_data_b  = rd_data_b;
  assign bus.rd_ready_a = rd_ready_a;
  assign bus.rd_ready_b = rd_ready_b;
  assign bus.claim_ack  = claim_ack;
  assign bus.pending    = pending;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed table of vectors, a reset-with-outstanding-claims
// sequence and a randomized run against a behavioural model of reg_file.
module tb_reg_file;

  localparam int W = 16;
  localparam int D = 16;

  typedef struct {
    bit          chk;
    bit          rst_n;
    bit          we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    bit          ce;
    logic [3:0]  ca;
    logic [15:0] e_da;
    logic [15:0] e_db;
    bit          e_ra;
    bit          e_rb;
    bit          e_ack;
    logic [15:0] e_pend;
  } vec_t;

  logic CLK = 1'b0;
  logic reset;

  reg_file_if #(.WIDTH(W), .DEPTH(D)) rf ();

  reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (rf)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [15:0] m_reg  [D];
  bit          m_pend [D];
  bit          m_valid = 1'b0;

  vec_t tbl [25];

  function automatic vec_t mk(bit chk, bit rst_n, bit we, int wa, int wd,
                              int ra, int rb, bit ce, int ca, int e_da,
                              int e_db, bit e_ra, bit e_rb, bit e_ack,
                              int e_pend);
    vec_t v;
    v.chk = chk; v.rst_n = rst_n; v.we = we; v.wa = 4'(wa); v.wd = 16'(wd);
    v.ra = 4'(ra); v.rb = 4'(rb); v.ce = ce; v.ca = 4'(ca);
    v.e_da = 16'(e_da); v.e_db = 16'(e_db); v.e_ra = e_ra; v.e_rb = e_rb;
    v.e_ack = e_ack; v.e_pend = 16'(e_pend);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit rst_n, input bit we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [3:0] ra,
                       input logic [3:0] rb, input bit ce, input logic [3:0] ca);
    reset         = rst_n;
    rf.wr_en      = we;
    rf.wr_addr    = wa;
    rf.wr_data    = wd;
    rf.rd_addr_a  = ra;
    rf.rd_addr_b  = rb;
    rf.claim_en   = ce;
    rf.claim_addr = ca;
  endtask

  // Expected values from the rules, using the currently driven inputs.
  function automatic logic [15:0] exp_data(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
`ifdef REG_FILE_BYPASS_EN
    if (rf.wr_en && a == rf.wr_addr) return rf.wr_data;
`endif
    return m_reg[a];
  endfunction

  function automatic bit exp_rdy(input logic [3:0] a);
    if (a == 4'd0) return 1'b1;
`ifdef REG_FILE_BYPASS_EN
    if (rf.wr_en && a == rf.wr_addr) return 1'b1;
`endif
    return !m_pend[a];
  endfunction

  function automatic bit exp_ack();
    if (!rf.claim_en) return 1'b0;
    if (rf.claim_addr == 4'd0) return 1'b1;
    if (!m_pend[rf.claim_addr]) return 1'b1;
    return rf.wr_en && (rf.wr_addr == rf.claim_addr);
  endfunction

  function automatic logic [15:0] exp_pend();
    logic [15:0] p;
    for (int i = 0; i < D; i++) p[i] = m_pend[i];
    return p;
  endfunction

  // Advance the model by one rising edge using the held inputs.
  task automatic model_edge();
    bit ack;
    ack = exp_ack();
    if (!reset) begin
      for (int i = 0; i < D; i++) begin
        m_reg[i]  = 16'h0000;
        m_pend[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      if (rf.wr_en) begin
        if (rf.wr_addr != 4'd0) m_reg[rf.wr_addr] = rf.wr_data;
        m_pend[rf.wr_addr] = 1'b0;
      end
      if (ack && rf.claim_addr != 4'd0) m_pend[rf.claim_addr] = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rd_data_a"},  32'(rf.rd_data_a),  32'(exp_data(rf.rd_addr_a)));
    chk({tag, " rd_data_b"},  32'(rf.rd_data_b),  32'(exp_data(rf.rd_addr_b)));
    chk({tag, " rd_ready_a"}, 32'(rf.rd_ready_a), 32'(exp_rdy(rf.rd_addr_a)));
    chk({tag, " rd_ready_b"}, 32'(rf.rd_ready_b), 32'(exp_rdy(rf.rd_addr_b)));
    chk({tag, " claim_ack"},  32'(rf.claim_ack),  32'(exp_ack()));
    chk({tag, " pending"},    32'(rf.pending),    32'(exp_pend()));
  endtask

  // One model-checked cycle: drive, sample mid-cycle, clock, update model.
  task automatic cyc(input string tag, input bit rst_n, input bit we,
                     input logic [3:0] wa, input logic [15:0] wd,
                     input logic [3:0] ra, input logic [3:0] rb,
                     input bit ce, input logic [3:0] ca);
    drive(rst_n, we, wa, wd, ra, rb, ce, ca);
    #3;
    if (m_valid) check_model(tag);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //            chk rst we wa wd      ra rb ce ca  e_da    e_db    ra rb ack pend
    tbl[0]  = mk(0, 0, 0, 0, 0,       0, 0, 0, 0,  0,      0,      1, 1, 0, 0);
    tbl[1]  = mk(1, 1, 1, 3, 'hBEEF,  3, 0, 0, 0,  0,      0,      1, 1, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0,       3, 3, 0, 0,  'hBEEF, 'hBEEF, 1, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0,       3, 0, 1, 5,  'hBEEF, 0,      1, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0,       3, 5, 0, 0,  0,      0,      1, 1, 0, 0);
    tbl[5]  = mk(1, 1, 1, 5, 'h1234,  5, 5, 0, 0,  0,      0,      1, 1, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0,       5, 5, 0, 0,  'h1234, 'h1234, 1, 1, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0,       7, 5, 1, 7,  0,      'h1234, 1, 1, 1, 0);
    tbl[8]  = mk(1, 1, 0, 0, 0,       7, 7, 1, 7,  0,      0,      0, 0, 0, 'h0080);
    tbl[9]  = mk(1, 1, 1, 7, 'h00AA,  7, 5, 0, 0,  0,      'h1234, 0, 1, 0, 'h0080);
    tbl[10] = mk(1, 1, 0, 0, 0,       7, 7, 0, 0,  'h00AA, 'h00AA, 1, 1, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 0,       2, 7, 1, 2,  0,      'h00AA, 1, 1, 1, 0);
    tbl[12] = mk(1, 1, 1, 2, 'h5555,  2, 7, 1, 2,  0,      'h00AA, 0, 1, 1, 'h0004);
    tbl[13] = mk(1, 1, 0, 0, 0,       2, 2, 0, 0,  'h5555, 'h5555, 0, 0, 0, 'h0004);
    tbl[14] = mk(1, 1, 1, 0, 'hFFFF,  0, 2, 1, 0,  0,      'h5555, 1, 0, 1, 'h0004);
    tbl[15] = mk(1, 1, 0, 0, 0,       0, 2, 0, 0,  0,      'h5555, 1, 0, 0, 'h0004);
    tbl[16] = mk(1, 1, 1, 9, 'h0A0A,  0, 0, 1, 9,  0,      0,      1, 1, 1, 'h0004);
    tbl[17] = mk(1, 1, 1, 9, 'h0B0B,  9, 2, 1, 9,  'h0A0A, 'h5555, 0, 0, 1, 'h0204);
    tbl[18] = mk(1, 1, 0, 0, 0,       9, 0, 1, 15, 'h0B0B, 0,      0, 1, 1, 'h0204);
    tbl[19] = mk(1, 1, 0, 0, 0,       15, 9, 0, 0, 0,      'h0B0B, 0, 0, 0, 'h8204);
    tbl[20] = mk(1, 1, 0, 0, 0,       4, 15, 1, 4, 0,      0,      1, 0, 1, 'h8204);
    tbl[21] = mk(1, 1, 1, 4, 'h9ABC,  4, 4, 0, 0,  0,      0,      0, 0, 0, 'h8214);
    tbl[22] = mk(1, 1, 0, 0, 0,       4, 15, 0, 0, 'h9ABC, 0,      1, 0, 0, 'h8204);
    tbl[23] = mk(1, 1, 1, 3, 'h1111,  3, 15, 1, 15, 0,     0,      1, 0, 0, 'h8204);
    tbl[24] = mk(1, 1, 0, 0, 0,       3, 15, 0, 0, 'h1111, 0,      1, 0, 0, 'h8204);
`ifdef REG_FILE_BYPASS_EN
    tbl[1].e_da  = 16'hBEEF;
    tbl[5].e_da  = 16'h1234; tbl[5].e_db = 16'h1234;
    tbl[9].e_da  = 16'h00AA; tbl[9].e_ra = 1'b1;
    tbl[12].e_da = 16'h5555; tbl[12].e_ra = 1'b1;
    tbl[17].e_da = 16'h0B0B; tbl[17].e_ra = 1'b1;
    tbl[21].e_da = 16'h9ABC; tbl[21].e_db = 16'h9ABC;
    tbl[21].e_ra = 1'b1;     tbl[21].e_rb = 1'b1;
    tbl[23].e_da = 16'h1111;
`endif

    drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0);
    @(posedge CLK);
    #1;

    // Directed table
    for (int i = 0; i < $size(tbl); i++) begin
      drive(tbl[i].rst_n, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra,
            tbl[i].rb, tbl[i].ce, tbl[i].ca);
      #3;
      if (tbl[i].chk) begin
        chk($sformatf("v%0d rd_data_a", i),  32'(rf.rd_data_a),  32'(tbl[i].e_da));
        chk($sformatf("v%0d rd_data_b", i),  32'(rf.rd_data_b),  32'(tbl[i].e_db));
        chk($sformatf("v%0d rd_ready_a", i), 32'(rf.rd_ready_a), 32'(tbl[i].e_ra));
        chk($sformatf("v%0d rd_ready_b", i), 32'(rf.rd_ready_b), 32'(tbl[i].e_rb));
        chk($sformatf("v%0d claim_ack", i),  32'(rf.claim_ack),  32'(tbl[i].e_ack));
        chk($sformatf("v%0d pending", i),    32'(rf.pending),    32'(tbl[i].e_pend));
      end
      @(posedge CLK);
      model_edge();
      #1;
    end

    // Reset with claims outstanding, then sweep every address.
    cyc("clm1", 1'b1, 1'b0, 4'd0, 16'h0, 4'd1, 4'd6, 1'b1, 4'd1);
    cyc("clm6", 1'b1, 1'b1, 4'd6, 16'h7777, 4'd1, 4'd6, 1'b1, 4'd6);
    cyc("clmB", 1'b1, 1'b0, 4'd0, 16'h0, 4'd1, 4'd6, 1'b1, 4'd11);
    cyc("rst", 1'b0, 1'b1, 4'd11, 16'hDEAD, 4'd6, 4'd11, 1'b1, 4'd12);
    for (int a = 0; a < D; a += 2) begin
      cyc($sformatf("sweep%0d", a), 1'b1, 1'b0, 4'd0, 16'h0, 4'(a), 4'(a + 1),
          1'b0, 4'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit          r_rst, r_we, r_ce;
      logic [3:0]  r_wa, r_ca, r_ra, r_rb;
      logic [15:0] r_wd;
      r_rst = ($urandom_range(0, 59) != 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_ce  = $urandom_range(0, 1) == 1;
      r_wa  = 4'($urandom_range(0, 15));
      r_wd  = 16'($urandom);
      r_ca  = ($urandom_range(0, 3) == 0) ? r_wa : 4'($urandom_range(0, 15));
      r_ra  = ($urandom_range(0, 4) == 0) ? r_wa : 4'($urandom_range(0, 15));
      r_rb  = ($urandom_range(0, 4) == 0) ? r_ca : 4'($urandom_range(0, 15));
      cyc($sformatf("rnd%0d", n), r_rst, r_we, r_wa, r_wd, r_ra, r_rb, r_ce, r_ca);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
